// File: rtl/hyperram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_wb_arbiter
// Purpose  : Two-master Wishbone arbiter in front of a HyperRAM controller.
//            Master 0 is the camera writer and master 1 is the SD reader.
//            The granted master's bus is forwarded combinationally to the
//            slave. Slave responses go back only to the granted master.
//            A grant is cut short in two cases:
//              - burst limit: the last allowed beat becomes a retry when the
//                other master is waiting;
//              - stall timeout: the strobe waits too long for an ack, which
//                ends in a one-cycle error pulse.
// Ports    : wb_clk, wb_rst          clock, synchronous active-high reset
//            mN_cyc/stb/we/adr/dat_w/sel   master N request (N = 0, 1)
//            mN_ack/err/rty/dat_r          master N response
//            s_cyc/stb/we/adr/dat_w/sel    forwarded request to the controller
//            s_ack/s_err/s_dat_r           controller response
// Options  : HRAM_ARB_ROUND_ROBIN_EN
//              defined   - simultaneous requests go to the master that did
//                          not hold the most recent grant
//              undefined - master 0 always wins simultaneous requests
// Revision : 1.0  initial release
// ============================================================================
module hyperram_wb_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  // master 0 (camera writer)
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_w,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  output logic                m0_err,
  output logic                m0_rty,
  output logic [DATA_W-1:0]   m0_dat_r,
  // master 1 (SD reader)
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_w,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic                m1_err,
  output logic                m1_rty,
  output logic [DATA_W-1:0]   m1_dat_r,
  // slave (HyperRAM controller)
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic                s_err,
  input  logic [DATA_W-1:0]   s_dat_r
);

  localparam int         TO_W      = $clog2(TIMEOUT) + 1;
  localparam logic [6:0] BEAT_LAST = 7'(MAX_BURST - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      beat_q, beat_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  // The timeout error is issued the cycle after the grant is dropped, so it
  // is held per master rather than routed through the grant mux.
  logic [1:0]      tmo_err_q, tmo_err_d;
`ifdef HRAM_ARB_ROUND_ROBIN_EN
  logic            last_grant_q, last_grant_d;
`endif

  logic gnt0, gnt1;
  logic cur_cyc, other_cyc;
  logic burst_end, tmo_hit;
  logic pick;

  // Reset masks the grant directly so an in-flight slave cycle is aborted
  // in the same cycle reset is seen.
  assign gnt0      = (state_q == GRANT0) && !wb_rst;
  assign gnt1      = (state_q == GRANT1) && !wb_rst;
  assign cur_cyc   = gnt0 ? m0_cyc : m1_cyc;
  assign other_cyc = gnt0 ? m1_cyc : m0_cyc;

  assign burst_end = (gnt0 || gnt1) && s_ack && (beat_q == BEAT_LAST) && other_cyc;
  assign tmo_hit   = s_stb && !s_ack && (tmo_q == TO_LAST);

  // Winner of an IDLE arbitration: 0 = master 0, 1 = master 1.
`ifdef HRAM_ARB_ROUND_ROBIN_EN
  assign pick = (m0_cyc && m1_cyc) ? ~last_grant_q : ~m0_cyc;
`else
  assign pick = ~m0_cyc;
`endif

  // Slave-side request mux.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    if (gnt0) begin
      s_cyc   = m0_cyc;
      s_stb   = m0_cyc & m0_stb;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_w = m0_dat_w;
      s_sel   = m0_sel;
    end else if (gnt1) begin
      s_cyc   = m1_cyc;
      s_stb   = m1_cyc & m1_stb;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_sel   = m1_sel;
    end
  end

  // Response routing; the beat that hits the burst limit becomes a retry.
  assign m0_ack   = gnt0 & s_ack & ~burst_end;
  assign m0_rty   = gnt0 & burst_end;
  assign m0_err   = (gnt0 & s_err) | (tmo_err_q[0] & ~wb_rst);
  assign m0_dat_r = gnt0 ? s_dat_r : '0;

  assign m1_ack   = gnt1 & s_ack & ~burst_end;
  assign m1_rty   = gnt1 & burst_end;
  assign m1_err   = (gnt1 & s_err) | (tmo_err_q[1] & ~wb_rst);
  assign m1_dat_r = gnt1 ? s_dat_r : '0;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    tmo_err_d = 2'b00;
`ifdef HRAM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        // Counters are held clear here so every grant starts from zero.
        beat_d = '0;
        tmo_d  = '0;
        if (m0_cyc || m1_cyc) begin
          state_d = pick ? GRANT1 : GRANT0;
`ifdef HRAM_ARB_ROUND_ROBIN_EN
          last_grant_d = pick;
`endif
        end
      end
      GRANT0, GRANT1: begin
        if (!cur_cyc || burst_end) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
          if (state_q == GRANT0) tmo_err_d[0] = 1'b1;
          else                   tmo_err_d[1] = 1'b1;
        end else if (s_ack) begin
          tmo_d = '0;
          // Saturate on the last beat so a late request still gets a retry.
          if (beat_q != BEAT_LAST) beat_d = beat_q + 7'd1;
        end else if (s_stb) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 2'b00;
`ifdef HRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
`ifdef HRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hyperram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperram_wb_arbiter
// Purpose  : Directed self-checking bench for hyperram_wb_arbiter. The slave
//            is modelled as acking every strobe while ack_en is set, with
//            read data derived from the address.
// Revision : 1.0  initial release
// ============================================================================
module tb_hyperram_wb_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [ADDR_W-1:0] m0_adr, m1_adr;
  logic [DATA_W-1:0] m0_dat_w, m1_dat_w;
  logic [3:0]        m0_sel, m1_sel;
  logic              m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [DATA_W-1:0] m0_dat_r, m1_dat_r;
  logic              s_cyc, s_stb, s_we;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat_w, s_dat_r;
  logic [3:0]        s_sel;
  logic              s_ack, s_err;
  logic              ack_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign s_ack   = ack_en & s_stb;
  assign s_dat_r = {8'hA5, s_adr};

  hyperram_wb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(64), .TIMEOUT(1024)
  ) dut (
    .wb_clk(clk), .wb_rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_rty(m0_rty), .m0_dat_r(m0_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_rty(m1_rty), .m1_dat_r(m1_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err),
    .s_dat_r(s_dat_r)
  );

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 24'h111111;
    m0_dat_w = 32'hCAFE0000; m0_sel = 4'hF;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 24'h222222;
    m1_dat_w = 32'hBEEF0000; m1_sel = 4'h3;
    s_err = 0; ack_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; ack_en = 1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL reset_s_cyc got=%0b exp=0", s_cyc); end
    total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL reset_s_stb got=%0b exp=0", s_stb); end
    total++; if ({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== 6'b0) begin
      bad++; $display("FAIL reset_resp got=%b exp=000000", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty});
    end
    @(negedge clk);
    rst = 0; idle_inputs();
  endtask

  // 4-beat write from m0; s_err injected on beat 3 must pass through only.
  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 24'h000100; ack_en = 1;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL wr_req_cycle s_cyc got=%0b exp=0", s_cyc); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_adr = 24'h000100 + 24'(i);
      s_err  = (i == 2);
      #1;
      total++; if (s_cyc !== 1'b1 || s_we !== 1'b1 || s_adr !== 24'h000100 + 24'(i)) begin
        bad++; $display("FAIL wr_fwd beat=%0d got cyc=%0b we=%0b adr=%h exp 1 1 %h", i, s_cyc, s_we, s_adr, 24'h000100 + 24'(i));
      end
      total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
        bad++; $display("FAIL wr_ack beat=%0d got m0=%0b m1=%0b exp 1 0", i, m0_ack, m1_ack);
      end
      total++; if (m0_err !== (i == 2) || m1_err !== 1'b0) begin
        bad++; $display("FAIL wr_err_pass beat=%0d got m0=%0b m1=%0b exp %0b 0", i, m0_err, m1_err, (i == 2));
      end
    end
    @(negedge clk);
    s_err = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    total++; if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
      bad++; $display("FAIL wr_release got cyc=%0b ack=%0b exp 0 0", s_cyc, m0_ack);
    end
    idle_inputs();
  endtask

  // Both request from reset; m0 then drops for one cycle and re-requests.
  task automatic test_simultaneous();
    logic exp_w;
`ifdef HRAM_ARB_ROUND_ROBIN_EN
    exp_w = 1'b1;
`else
    exp_w = 1'b0;
`endif
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; ack_en = 1;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL sim_idle got=%0b exp=0", s_cyc); end
    @(negedge clk); #1;
    total++; if (s_cyc !== 1'b1 || s_adr !== 24'h111111 || m0_ack !== 1'b1 || m1_ack !== 1'b0 || m1_rty !== 1'b0) begin
      bad++; $display("FAIL sim_first got adr=%h m0_ack=%0b m1_ack=%0b exp 111111 1 0", s_adr, m0_ack, m1_ack);
    end
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL sim_drop got=%0b exp=0", s_cyc); end
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL sim_idle2 got=%0b exp=0", s_cyc); end
    @(negedge clk); #1;
    total++; if (s_adr !== (exp_w ? 24'h222222 : 24'h111111) || m0_ack !== ~exp_w || m1_ack !== exp_w) begin
      bad++; $display("FAIL sim_second got adr=%h m0_ack=%0b m1_ack=%0b exp winner m%0d", s_adr, m0_ack, m1_ack, exp_w);
    end
    @(negedge clk);
    if (exp_w) begin m1_cyc = 0; m1_stb = 0; end
    else       begin m0_cyc = 0; m0_stb = 0; end
    @(negedge clk); #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL sim_idle3 got=%0b exp=0", s_cyc); end
    @(negedge clk); #1;
    total++; if (s_adr !== (exp_w ? 24'h111111 : 24'h222222) || m0_ack !== exp_w || m1_ack !== ~exp_w) begin
      bad++; $display("FAIL sim_loser got adr=%h m0_ack=%0b m1_ack=%0b exp loser granted", s_adr, m0_ack, m1_ack);
    end
    idle_inputs();
  endtask

  // m1 long read with m0 waiting: 63 acks, retry on beat 64, then m0 granted.
  task automatic test_burst_retry();
    int acks = 0;
    int rty_beat = 0;
    do_reset();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; ack_en = 1;
    #1;
    for (int b = 1; b <= 100 && rty_beat == 0; b++) begin
      @(negedge clk);
      m0_cyc = 1; m0_stb = 1;
      #1;
      if (b == 1) begin
        total++; if (m1_dat_r !== 32'hA5222222 || m0_dat_r !== 32'h0) begin
          bad++; $display("FAIL rd_data got m1=%h m0=%h exp a5222222 0", m1_dat_r, m0_dat_r);
        end
      end
      if (m1_rty === 1'b1) begin
        rty_beat = b;
        total++; if (m1_ack !== 1'b0 || m0_ack !== 1'b0) begin
          bad++; $display("FAIL rty_ack got m1=%0b m0=%0b exp 0 0", m1_ack, m0_ack);
        end
      end else if (m1_ack === 1'b1) acks++;
    end
    total++; if (rty_beat != 64) begin bad++; $display("FAIL rty_beat got=%0d exp=64", rty_beat); end
    total++; if (acks != 63) begin bad++; $display("FAIL rty_acks got=%0d exp=63", acks); end
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL rty_idle got=%0b exp=0", s_cyc); end
    @(negedge clk); #1;
    total++; if (s_adr !== 24'h111111 || m0_ack !== 1'b1) begin
      bad++; $display("FAIL rty_next got adr=%h m0_ack=%0b exp 111111 1", s_adr, m0_ack);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int err_n = 0;
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1;
    #1;
    for (int n = 1; n <= 1200 && err_n == 0; n++) begin
      @(negedge clk); #1;
      if (m0_err === 1'b1) begin
        err_n = n;
        total++; if (s_cyc !== 1'b0 || m1_err !== 1'b0) begin
          bad++; $display("FAIL tmo_drop got s_cyc=%0b m1_err=%0b exp 0 0", s_cyc, m1_err);
        end
        m0_cyc = 0; m0_stb = 0;
      end
    end
    total++; if (err_n != 1025) begin bad++; $display("FAIL tmo_cycle got=%0d exp=1025", err_n); end
    @(negedge clk); #1;
    total++; if (m0_err !== 1'b0 || s_cyc !== 1'b0) begin
      bad++; $display("FAIL tmo_pulse got err=%0b cyc=%0b exp 0 0", m0_err, s_cyc);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_we = 1; ack_en = 1;
    @(negedge clk); #1;
    total++; if (m0_ack !== 1'b1) begin bad++; $display("FAIL mid_beat1 got=%0b exp=1", m0_ack); end
    @(negedge clk);
    rst = 1;
    #1;
    total++; if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
      bad++; $display("FAIL mid_abort got cyc=%0b ack=%0b exp 0 0", s_cyc, m0_ack);
    end
    @(negedge clk); #1;
    total++; if (s_cyc !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      bad++; $display("FAIL mid_held got cyc=%0b ack0=%0b ack1=%0b exp 0 0 0", s_cyc, m0_ack, m1_ack);
    end
    @(negedge clk);
    rst = 0;
    #1;
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0b exp=0", s_cyc); end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_burst_retry();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
